// File: rtl/rf_seq_pkg.sv
// Shared definitions for rf_seq_ctrl: opcodes, FSM encoding, default widths.
// Flag registers are only built when RF_SEQ_FLAGS_EN is defined.
package rf_seq_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;

    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_OUT = 3'd7;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRead   = 2'd1,
        StWrite  = 2'd2,
        StResult = 2'd3
    } state_e;

    // Ops that update the status flags (ADD..XOR)
    function automatic logic is_flag_op(input logic [2:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Single-cycle combinational ALU for rf_seq_ctrl.
// carry_o is the ADD carry-out or the SUB borrow; zero for all other ops.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    // The extra top bit of the widened difference is the unsigned borrow
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        unique case (op_i)
            OP_LDI: result_o = imm_i;
            OP_MOV: result_o = a_i;
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_OUT: result_o = a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Instruction-driven read/write master for an 8x8 register file, with an OUT result stream.
// Define RF_SEQ_FLAGS_EN to build the zero/carry flag registers; otherwise flags are tied low.
module rf_seq_ctrl
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [2:0]        ins_op,
    input  logic [ADDR_W-1:0] ins_rd,
    input  logic [ADDR_W-1:0] ins_rs,
    input  logic [ADDR_W-1:0] ins_rt,
    input  logic [DATA_W-1:0] ins_imm,
    output logic              WEN,
    output logic [ADDR_W-1:0] RW,
    output logic [ADDR_W-1:0] RX,
    output logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busW,
    input  logic [DATA_W-1:0] busX,
    input  logic [DATA_W-1:0] busY,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              flag_z,
    output logic              flag_c
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] rx_q, rx_d;
    logic [ADDR_W-1:0] ry_q, ry_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] busw_q, busw_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    rf_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op_q),
        .a_i      (busX),
        .b_i      (busY),
        .imm_i    (imm_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            wen_q       <= 1'b0;
            rw_q        <= '0;
            busw_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            wen_q       <= wen_d;
            rw_q        <= rw_d;
            busw_q      <= busw_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        wen_d       = wen_q;
        rw_d        = rw_q;
        busw_d      = busw_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        ins_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                ins_ready = 1'b1;
                if (ins_valid) begin
                    op_d    = ins_op;
                    rd_d    = ins_rd;
                    imm_d   = ins_imm;
                    rx_d    = ins_rs;
                    ry_d    = ins_rt;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (op_q == OP_OUT) begin
                    res_data_d  = busX;
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end else begin
                    wen_d   = 1'b1;
                    rw_d    = rd_q;
                    busw_d  = alu_result;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Register file commits on the edge that closes this cycle
                wen_d   = 1'b0;
                state_d = StIdle;
            end
            StResult: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef RF_SEQ_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (state_q == StRead && is_flag_op(op_q)) begin
            flag_z_d = (alu_result == '0);
            flag_c_d = alu_carry;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    logic unused_alu_carry;
    assign unused_alu_carry = alu_carry;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

    assign WEN       = wen_q;
    assign RW        = rw_q;
    assign RX        = rx_q;
    assign RY        = ry_q;
    assign busW      = busw_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl: attached 8x8 register file, directed plan, then random ops.
// Expected flags follow RF_SEQ_FLAGS_EN when the bench is built with it.
module tb_rf_seq_ctrl;
    import rf_seq_pkg::*;

`ifdef RF_SEQ_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       ins_valid = 1'b0;
    logic       ins_ready;
    logic [2:0] ins_op = '0;
    logic [2:0] ins_rd = '0, ins_rs = '0, ins_rt = '0;
    logic [7:0] ins_imm = '0;
    logic       WEN;
    logic [2:0] RW, RX, RY;
    logic [7:0] busW, busX, busY;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       flag_z, flag_c;

    logic [7:0] rf [8];
    logic       rf_clr = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] ref_rf [8];
    logic       ref_z = 1'b0;
    logic       ref_c = 1'b0;

    always #5 Clk = ~Clk;

    rf_seq_ctrl u_dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_op    (ins_op),
        .ins_rd    (ins_rd),
        .ins_rs    (ins_rs),
        .ins_rt    (ins_rt),
        .ins_imm   (ins_imm),
        .WEN       (WEN),
        .RW        (RW),
        .RX        (RX),
        .RY        (RY),
        .busW      (busW),
        .busX      (busX),
        .busY      (busY),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    always @(posedge Clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (WEN) begin
            rf[RW] <= busW;
        end
    end

    assign busX = rf[RX];
    assign busY = rf[RY];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wen"}, WEN, 0);
        chk({tag, "_rw"}, RW, 0);
        chk({tag, "_rx"}, RX, 0);
        chk({tag, "_ry"}, RY, 0);
        chk({tag, "_busw"}, busW, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_flag_z"}, flag_z, 0);
        chk({tag, "_flag_c"}, flag_c, 0);
        chk({tag, "_ins_ready"}, ins_ready, 1);
    endtask

    // Behavioural result: plain integer arithmetic on the operand values
    task automatic model(input logic [2:0] op, input int a, input int b, input int imm,
                         output logic [7:0] res, output logic c);
        int r;
        c = 1'b0;
        case (op)
            0: r = imm;
            1: r = a;
            2: begin r = a + b; c = (r > 255); end
            3: begin r = a - b; c = (a < b); if (r < 0) r += 256; end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = a;
        endcase
        res = r[7:0];
    endtask

    // Entered and left at a negedge with the DUT idle
    task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [7:0] imm, input bit hold,
                       input int stall);
        logic [7:0] res;
        logic       c;
        string      nm;
        nm = $sformatf("op%0d", op);
        chk({nm, "_ready_idle"}, ins_ready, 1);
        model(op, int'(ref_rf[rs]), int'(ref_rf[rt]), int'(imm), res, c);
        ins_op = op; ins_rd = rd; ins_rs = rs; ins_rt = rt; ins_imm = imm;
        ins_valid = 1'b1;
        @(negedge Clk);
        if (hold) begin
            ins_op = 3'($urandom); ins_rd = 3'($urandom); ins_rs = 3'($urandom);
            ins_rt = 3'($urandom); ins_imm = 8'($urandom);
        end else begin
            ins_valid = 1'b0;
        end
        chk({nm, "_ready_read"}, ins_ready, 0);
        chk({nm, "_wen_read"}, WEN, 0);
        chk({nm, "_rx"}, RX, rs);
        chk({nm, "_ry"}, RY, rt);
        if (op == OP_OUT) begin
            @(negedge Clk);
            for (int i = 0; i <= stall; i++) begin
                chk({nm, "_res_valid"}, res_valid, 1);
                chk({nm, "_res_data"}, res_data, ref_rf[rs]);
                chk({nm, "_ready_result"}, ins_ready, 0);
                chk({nm, "_wen_result"}, WEN, 0);
                if (i == stall) res_ready = 1'b1;
                @(negedge Clk);
            end
            res_ready = 1'b0;
            chk({nm, "_res_valid_done"}, res_valid, 0);
            chk({nm, "_ready_done"}, ins_ready, 1);
            chk({nm, "_flag_z_keep"}, flag_z, ref_z);
            chk({nm, "_flag_c_keep"}, flag_c, ref_c);
        end else begin
            @(negedge Clk);
            if (FlagsEn && op >= 2 && op <= 6) begin
                ref_z = (res == 8'h00);
                ref_c = c;
            end
            chk({nm, "_wen_write"}, WEN, 1);
            chk({nm, "_rw"}, RW, rd);
            chk({nm, "_busw"}, busW, res);
            chk({nm, "_ready_write"}, ins_ready, 0);
            chk({nm, "_flag_z"}, flag_z, ref_z);
            chk({nm, "_flag_c"}, flag_c, ref_c);
            ref_rf[rd] = res;
            @(negedge Clk);
            chk({nm, "_wen_idle"}, WEN, 0);
            chk({nm, "_ready_idle2"}, ins_ready, 1);
            chk({nm, "_rf_commit"}, rf[rd], ref_rf[rd]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
        Rst_n = 1'b0;
        rf_clr = 1'b1;
        repeat (2) @(negedge Clk);
        rf_clr = 1'b0;
        chk_reset_outputs("por");
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("por_ready_after", ins_ready, 1);

        // Directed plan
        run(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h0F, 1'b0, 0);
        run(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hF1, 1'b0, 0);
        run(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 0);
        run(OP_SUB, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0, 0);
        run(OP_XOR, 3'd5, 3'd4, 3'd4, 8'h00, 1'b0, 0);
        run(OP_OUT, 3'd0, 3'd2, 3'd0, 8'h00, 1'b0, 5);
        run(OP_LDI, 3'd6, 3'd0, 3'd0, 8'hAA, 1'b1, 0);
        run(OP_MOV, 3'd7, 3'd6, 3'd0, 8'h00, 1'b0, 0);
        chk("mov_r7", rf[7], 8'hAA);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            run(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
                8'($urandom), 1'b0, int'($urandom_range(0, 3)));
        end

        // Reset during WRITE: the write still lands
        ins_op = OP_LDI; ins_rd = 3'd0; ins_imm = 8'h55; ins_valid = 1'b1;
        @(negedge Clk);
        ins_valid = 1'b0;
        @(negedge Clk);
        chk("rstw_wen", WEN, 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk_reset_outputs("rstw");
        chk("rstw_r0", rf[0], 8'h55);
        ref_rf[0] = 8'h55; ref_z = 1'b0; ref_c = 1'b0;
        Rst_n = 1'b1;
        @(negedge Clk);

        // Reset during READ: no write
        ins_op = OP_LDI; ins_rd = 3'd0; ins_imm = 8'h66; ins_valid = 1'b1;
        @(negedge Clk);
        ins_valid = 1'b0;
        Rst_n = 1'b0;
        @(negedge Clk);
        chk_reset_outputs("rstr");
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rstr_wen", WEN, 0);
        chk("rstr_r0", rf[0], 8'h55);

        // Reset during RESULT: word discarded
        ins_op = OP_OUT; ins_rs = 3'd0; ins_valid = 1'b1;
        @(negedge Clk);
        ins_valid = 1'b0;
        @(negedge Clk);
        chk("rsto_valid", res_valid, 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk_reset_outputs("rsto");
        Rst_n = 1'b1;
        @(negedge Clk);

        run(OP_ADD, 3'd1, 3'd0, 3'd0, 8'h00, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_seq_ctrl.md
# rf_seq_ctrl

Instruction-driven initiator for the 8x8 register file: accepts one three-operand instruction per valid/ready handshake, drives the register file's read-select, write-select and write bus, performs a one-cycle ALU operation and writes back. Sits between the instruction source and the register file as its sole read/write master; can also stream a register's contents out over a result handshake.

## Interface
- DATA_W, 8, register and bus width
- ADDR_W, 3, register select width (2**ADDR_W registers)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset; one clock, reset is synchronous and active-low
- ins_valid  in  1  instruction offered
- ins_ready  out  1  instruction accepted when ins_valid && ins_ready at posedge
- ins_op  in  3  opcode
- ins_rd / ins_rs / ins_rt  in  ADDR_W each  destination, source A, source B
- ins_imm  in  DATA_W  immediate (LDI only)
- WEN  out  1  register file write enable (registered)
- RW  out  ADDR_W  write select (registered)
- RX / RY  out  ADDR_W each  read selects (registered)
- busW  out  DATA_W  write data (registered)
- busX / busY  in  DATA_W  combinational read data from register file
- res_valid  out  1  result word available (OUT op)
- res_ready  in  1  consumer takes result
- res_data  out  DATA_W  result word
- flag_z / flag_c  out  1  zero / carry status

## Operation
- Opcodes: 0 LDI rd<=imm; 1 MOV rd<=rs; 2 ADD rd<=rs+rt; 3 SUB rd<=rs-rt; 4 AND; 5 OR; 6 XOR; 7 OUT res_data<=rs, no write.
- Arithmetic modulo 2**DATA_W; ADD carry = bit DATA_W of the (DATA_W+1)-bit sum; SUB carry = borrow (rs < rt unsigned).
- FSM states IDLE, READ, WRITE, RESULT.
- IDLE: ins_ready=1; on handshake latch op/rd/imm, RX<=rs, RY<=rt, go READ.
- READ: busX/busY valid; capture operands, compute result. If op!=OUT: WEN<=1, RW<=rd, busW<=result, go WRITE. If OUT: res_data<=busX, res_valid<=1, go RESULT.
- WRITE: register file commits at the closing edge; WEN<=0, go IDLE.
- RESULT: hold res_valid and res_data stable until res_ready; on res_valid && res_ready, res_valid<=0, go IDLE.
- ins_ready low in all states except IDLE; instructions not accepted while a result is pending.
- Every op, including LDI and OUT, passes through READ (uniform latency).

## Timing
- Reset (Rst_n low at posedge): state IDLE; WEN=0, RW=RX=RY=0, busW=0, res_valid=0, res_data=0, flag_z=flag_c=0; ins_ready=1 from the next cycle.
- Write latency: accept at edge T0, operands captured at T1, register file updated at T2; ins_ready high during cycle T2-T3. Throughput one write op per 3 cycles.
- Back-to-back dependent instructions are safe: the next READ occurs after the T2 write edge.
- OUT: res_valid rises after T1; earliest completion at T2 with res_ready held high.
- Reset sampled at T2 (WRITE cycle): write still commits (register file sees WEN=1 at that edge), block returns IDLE. Reset during READ: no write occurs. Reset during RESULT: res_valid drops, word discarded.
- ins_valid during non-IDLE states is ignored; no instruction buffering.

## Configuration
- RF_SEQ_FLAGS_EN defined: flag_z/flag_c registered at the READ->WRITE edge for ops 2-6 (flag_z = result==0; flag_c per arithmetic rule, cleared by AND/OR/XOR); LDI, MOV and OUT leave flags unchanged.
- Not defined: no flag registers; flag_z and flag_c tied 0; datapath otherwise identical.

## Structure
- Package rf_seq_pkg: opcode constants (OP_LDI..OP_OUT), FSM state encoding, DATA_W/ADDR_W defaults.
- One sub-module rf_seq_alu: combinational op, a, b, imm -> result, carry; instantiated once in the READ datapath.

## Test plan
- After reset: LDI r1,0x0F then LDI r2,0xF1 -> WEN pulses 1 cycle each, RW=1/busW=0x0F then RW=2/busW=0xF1, ins_ready low 2 cycles per op.
- ADD r3,r1,r2 -> busW=0x00; with RF_SEQ_FLAGS_EN flag_c=1, flag_z=1.
- SUB r4,r1,r2 -> busW=0x1E, flag_c=1 (borrow); then XOR r5,r4,r4 -> busW=0x00, flag_c=0.
- OUT r2 with res_ready low 5 cycles -> res_valid high and res_data=0xF1 stable throughout, ins_ready low, no WEN pulse; completes the cycle res_ready rises.
- Back-to-back LDI r6,0xAA; MOV r7,r6 with ins_valid held high -> second op reads busX=0xAA, writes r7=0xAA.
- Rst_n low during WRITE of LDI r0,0x55 -> r0 holds 0x55, all outputs at reset values next cycle; Rst_n low during READ of LDI r0,0x66 -> no WEN pulse, r0 unchanged.
